conv_sched: RTL and testbench

// Sequencer for one convolution pass: takes layer config from the CSR block, walks every output pixel and kernel tap,

---
 rtl/conv_sched.sv | 246 ++++++++++++++++++++++++
 tb/tb_conv_sched.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_sched.sv
// conv_sched: sequences FRAM/KRAM reads over every output pixel and kernel tap of one conv pass.
// Define CONV_SCHED_PERF_EN to add the perf_cycles/perf_stalls counters.
module conv_sched #(
    parameter int ADDR_WIDTH = 12,
    parameter int DIM_W      = 8,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIM_W-1:0]      cfg_ih,
    input  logic [DIM_W-1:0]      cfg_iw,
    input  logic [DIM_W-1:0]      cfg_ch,
    input  logic [DIM_W-1:0]      cfg_k,
    input  logic                  cfg_stride2,
    input  logic [ADDR_WIDTH-1:0] cfg_fbase,
    input  logic [ADDR_WIDTH-1:0] cfg_kbase,
    input  logic                  stall,
    output logic                  fram_rd_en,
    output logic [ADDR_WIDTH-1:0] fram_rd_addr,
    output logic                  kram_rd_en,
    output logic [ADDR_WIDTH-1:0] kram_rd_addr,
    output logic                  mac_valid,
    output logic                  mac_first,
    output logic                  mac_last,
    output logic [2*DIM_W-1:0]    out_idx,
    output logic                  busy,
    output logic                  done,
`ifdef CONV_SCHED_PERF_EN
    output logic [31:0]           perf_cycles,
    output logic [31:0]           perf_stalls,
`endif
    output logic                  err
);

    localparam int AW = ADDR_WIDTH;
    localparam int IW = 2 * DIM_W;
    localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_RUN, S_DRAIN, S_FIN
    } state_t;

    state_t state;

    logic [DIM_W-1:0] ih, iw, ch, kk;
    logic             s;
    logic [AW-1:0]    fbase, kbase;
    logic [DIM_W-1:0] oy, ox, c, ky, kx;
    logic [DIM_W-1:0] nxt_oy, nxt_ox, nxt_c, nxt_ky, nxt_kx;
    logic [DIM_W-1:0] oh, ow;
    logic             bad, issue;
    logic             last_kx, last_ky, last_c, last_ox, last_oy;
    logic             is_first, is_last, is_final;
    logic [AW-1:0]    row, col, fa, ka;
    logic [IW-1:0]    idx;

    logic             iss_first, iss_last;
    logic [IW-1:0]    iss_idx;
    logic [RD_LAT-1:0] pv, pf, pl;
    logic [IW-1:0]    pidx [RD_LAT];
    logic             early;

    assign oh = ((ih - kk) >> s) + ONE;
    assign ow = ((iw - kk) >> s) + ONE;
    assign bad = (kk == '0) || (ch == '0) || (kk > ih) || (kk > iw);

    assign last_kx  = (kx == kk - ONE);
    assign last_ky  = (ky == kk - ONE);
    assign last_c   = (c == ch - ONE);
    assign last_ox  = (ox == ow - ONE);
    assign last_oy  = (oy == oh - ONE);
    assign is_first = (c == '0) && (ky == '0) && (kx == '0);
    assign is_last  = last_kx && last_ky && last_c;
    assign is_final = is_last && last_ox && last_oy;

    // Tap 0 is issued on the CHECK edge so the first read lands at t+2.
    assign issue = ((state == S_CHECK) && !bad) ||
                   ((state == S_RUN) && !stall);

    // All arithmetic is done mod 2^AW, which gives the silent address wrap.
    assign row = (AW'(oy) << s) + AW'(ky);
    assign col = (AW'(ox) << s) + AW'(kx);
    assign fa  = fbase + AW'(c) * AW'(ih) * AW'(iw) + row * AW'(iw) + col;
    assign ka  = kbase + AW'(c) * AW'(kk) * AW'(kk) + AW'(ky) * AW'(kk)
               + AW'(kx);
    assign idx = IW'(oy) * IW'(ow) + IW'(ox);

    always_comb begin
        nxt_kx = kx + ONE;
        nxt_ky = ky;
        nxt_c  = c;
        nxt_ox = ox;
        nxt_oy = oy;
        if (last_kx) begin
            nxt_kx = '0;
            nxt_ky = ky + ONE;
            if (last_ky) begin
                nxt_ky = '0;
                nxt_c  = c + ONE;
                if (last_c) begin
                    nxt_c  = '0;
                    nxt_ox = ox + ONE;
                    if (last_ox) begin
                        nxt_ox = '0;
                        nxt_oy = oy + ONE;
                    end
                end
            end
        end
    end

    always_comb begin
        early = 1'b0;
        for (int i = 0; i < RD_LAT - 1; i++) early = early | pv[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            ih           <= '0;
            iw           <= '0;
            ch           <= '0;
            kk           <= '0;
            s            <= 1'b0;
            fbase        <= '0;
            kbase        <= '0;
            oy           <= '0;
            ox           <= '0;
            c            <= '0;
            ky           <= '0;
            kx           <= '0;
            fram_rd_en   <= 1'b0;
            fram_rd_addr <= '0;
            kram_rd_addr <= '0;
            iss_first    <= 1'b0;
            iss_last     <= 1'b0;
            iss_idx      <= '0;
            pv           <= '0;
            pf           <= '0;
            pl           <= '0;
            for (int i = 0; i < RD_LAT; i++) pidx[i] <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
`ifdef CONV_SCHED_PERF_EN
            perf_cycles  <= '0;
            perf_stalls  <= '0;
`endif
        end else begin
            fram_rd_en <= 1'b0;
            iss_first  <= 1'b0;
            iss_last   <= 1'b0;
            done       <= 1'b0;

            pv[0]   <= fram_rd_en;
            pf[0]   <= iss_first;
            pl[0]   <= iss_last;
            pidx[0] <= iss_idx;
            for (int i = 1; i < RD_LAT; i++) begin
                pv[i]   <= pv[i-1];
                pf[i]   <= pf[i-1];
                pl[i]   <= pl[i-1];
                pidx[i] <= pidx[i-1];
            end

            if (issue) begin
                fram_rd_en   <= 1'b1;
                fram_rd_addr <= fa;
                kram_rd_addr <= ka;
                iss_first    <= is_first;
                iss_last     <= is_last;
                iss_idx      <= idx;
                oy           <= nxt_oy;
                ox           <= nxt_ox;
                c            <= nxt_c;
                ky           <= nxt_ky;
                kx           <= nxt_kx;
            end

`ifdef CONV_SCHED_PERF_EN
            if (state == S_IDLE && start) begin
                perf_cycles <= '0;
                perf_stalls <= '0;
            end else begin
                if (busy && !(&perf_cycles))
                    perf_cycles <= perf_cycles + 32'd1;
                if (state == S_RUN && stall && !(&perf_stalls))
                    perf_stalls <= perf_stalls + 32'd1;
            end
`endif

            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        ih    <= cfg_ih;
                        iw    <= cfg_iw;
                        ch    <= cfg_ch;
                        kk    <= cfg_k;
                        s     <= cfg_stride2;
                        fbase <= cfg_fbase;
                        kbase <= cfg_kbase;
                        oy    <= '0;
                        ox    <= '0;
                        c     <= '0;
                        ky    <= '0;
                        kx    <= '0;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (bad) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_FIN;
                    end else begin
                        state <= is_final ? S_DRAIN : S_RUN;
                    end
                end
                S_RUN: begin
                    if (!stall && is_final) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    // Final beat sits at the pipe output: done follows next cycle.
                    if (!fram_rd_en && !early) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_FIN;
                    end
                end
                S_FIN: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign kram_rd_en = fram_rd_en;
    assign mac_valid  = pv[RD_LAT-1];
    assign mac_first  = pf[RD_LAT-1];
    assign mac_last   = pl[RD_LAT-1];
    assign out_idx    = pidx[RD_LAT-1];

endmodule

// File: tb/tb_conv_sched.sv
// tb_conv_sched: random and directed conv passes checked against a loop-nest model.
// Build with CONV_SCHED_PERF_EN defined to also check the perf counters.
module tb_conv_sched;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int RL = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] cfg_ih = '0, cfg_iw = '0, cfg_ch = '0, cfg_k = '0;
    logic          cfg_stride2 = 1'b0;
    logic [AW-1:0] cfg_fbase = '0, cfg_kbase = '0;
    logic          stall = 1'b0;
    logic          fram_rd_en, kram_rd_en;
    logic [AW-1:0] fram_rd_addr, kram_rd_addr;
    logic          mac_valid, mac_first, mac_last;
    logic [2*DW-1:0] out_idx;
    logic          busy, done, err;
`ifdef CONV_SCHED_PERF_EN
    logic [31:0]   perf_cycles, perf_stalls;
`endif

    conv_sched #(.ADDR_WIDTH(AW), .DIM_W(DW), .RD_LAT(RL)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_ih(cfg_ih), .cfg_iw(cfg_iw), .cfg_ch(cfg_ch), .cfg_k(cfg_k),
        .cfg_stride2(cfg_stride2),
        .cfg_fbase(cfg_fbase), .cfg_kbase(cfg_kbase), .stall(stall),
        .fram_rd_en(fram_rd_en), .fram_rd_addr(fram_rd_addr),
        .kram_rd_en(kram_rd_en), .kram_rd_addr(kram_rd_addr),
        .mac_valid(mac_valid), .mac_first(mac_first), .mac_last(mac_last),
        .out_idx(out_idx), .busy(busy), .done(done),
`ifdef CONV_SCHED_PERF_EN
        .perf_cycles(perf_cycles), .perf_stalls(perf_stalls),
`endif
        .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    typedef struct { int fa; int ka; } iss_t;
    typedef struct { bit f; bit l; int idx; } mac_t;

    iss_t exp_iss[$];
    mac_t exp_mac[$];
    int   obs_f[$], obs_k[$], obs_idx[$];
    bit   st_at[int];
    int   n_rd, n_last, n_first, n_done;
    int   first_rd_cyc, last_rd_cyc, last_mv_cyc, done_cyc;
    bit [RL-1:0] hist = '0;
    iss_t mon_i;
    mac_t mon_m;

    // Per-cycle compare of the DUT against the queued loop-nest model.
    always @(negedge clk) begin
        if (rst) begin
            hist = '0;
        end else begin
            chk("mac_valid_lat", mac_valid, hist[RL-1]);
            for (int i = RL - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = fram_rd_en;
            chk("kram_en_eq", kram_rd_en, fram_rd_en);
            st_at[cyc] = stall;
            if (fram_rd_en) begin
                n_rd++;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                last_rd_cyc = cyc;
                obs_f.push_back(int'(fram_rd_addr));
                obs_k.push_back(int'(kram_rd_addr));
                if (exp_iss.size() == 0) begin
                    chk("extra_issue", 1, 0);
                end else begin
                    mon_i = exp_iss.pop_front();
                    chk("fram_addr", fram_rd_addr, mon_i.fa);
                    chk("kram_addr", kram_rd_addr, mon_i.ka);
                end
            end
            if (mac_valid) begin
                last_mv_cyc = cyc;
                if (mac_first) n_first++;
                if (exp_mac.size() == 0) begin
                    chk("extra_mac", 1, 0);
                end else begin
                    mon_m = exp_mac.pop_front();
                    chk("mac_first", mac_first, mon_m.f);
                    chk("mac_last", mac_last, mon_m.l);
                    if (mon_m.l) begin
                        n_last++;
                        obs_idx.push_back(int'(out_idx));
                        chk("out_idx", out_idx, mon_m.idx);
                    end
                end
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
                chk("busy_at_done", busy, 0);
            end
        end
    end

    task automatic scramble();
        cfg_ih      = DW'($urandom);
        cfg_iw      = DW'($urandom);
        cfg_ch      = DW'($urandom);
        cfg_k       = DW'($urandom);
        cfg_stride2 = 1'($urandom);
        cfg_fbase   = AW'($urandom);
        cfg_kbase   = AW'($urandom);
    endtask

    task automatic chk_zero(input string name);
        chk(name, {fram_rd_en, kram_rd_en, fram_rd_addr, kram_rd_addr,
                   mac_valid, mac_first, mac_last, out_idx,
                   busy, done, err}, 0);
    endtask

    // mode 0: plain, 1: random stalls, 2: 3-cycle stall, 3: reset mid-run
    task automatic run_cfg(input int ih, input int iw, input int ch,
                           input int k, input int s, input int fb,
                           input int kb, input int mode);
        int oh, ow, st, t, budget, stalls, tot;
        bit bad, aborted;
        exp_iss.delete();
        exp_mac.delete();
        obs_f.delete();
        obs_k.delete();
        obs_idx.delete();
        st_at.delete();
        n_rd = 0; n_last = 0; n_first = 0; n_done = 0;
        first_rd_cyc = -1; last_rd_cyc = -1;
        last_mv_cyc = -1; done_cyc = -1;
        oh = 0; ow = 0;
        bad = (k == 0) || (ch == 0) || (k > ih) || (k > iw);
        st = s ? 2 : 1;
        if (!bad) begin
            oh = ((ih - k) >> s) + 1;
            ow = ((iw - k) >> s) + 1;
            for (int y = 0; y < oh; y++)
                for (int x = 0; x < ow; x++)
                    for (int cc = 0; cc < ch; cc++)
                        for (int ty = 0; ty < k; ty++)
                            for (int tx = 0; tx < k; tx++) begin
                                exp_iss.push_back('{
                                    (fb + cc*ih*iw + (y*st+ty)*iw + x*st+tx) % 4096,
                                    (kb + cc*k*k + ty*k + tx) % 4096});
                                exp_mac.push_back('{
                                    (cc == 0 && ty == 0 && tx == 0),
                                    (cc == ch-1 && ty == k-1 && tx == k-1),
                                    y*ow + x});
                            end
        end
        tot = exp_iss.size();

        @(posedge clk); #1;
        cfg_ih = DW'(ih); cfg_iw = DW'(iw); cfg_ch = DW'(ch); cfg_k = DW'(k);
        cfg_stride2 = 1'(s); cfg_fbase = AW'(fb); cfg_kbase = AW'(kb);
        start = 1'b1;
        t = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        scramble();
        chk("busy_accept", busy, 1);
        chk("err_cleared", err, 0);

        budget = 8 * (tot + 1) + 40;
        aborted = 1'b0;
        for (int i = 0; i < budget && done_cyc < 0 && !aborted; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            stall = 1'b0;
            if (mode == 1) stall = ($urandom_range(0, 3) == 0);
            if (mode == 2) stall = (cyc >= t + 5 && cyc <= t + 7);
            if ((mode == 1 || mode == 2) && busy && cyc == t + 4) begin
                start = 1'b1;
                scramble();
            end
            if (mode == 3 && cyc == t + 6) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                chk_zero("rst_mid_zero");
                aborted = 1'b1;
            end
        end
        start = 1'b0;
        stall = 1'b0;

        if (aborted) begin
            repeat (6) @(posedge clk);
            #1;
            chk("rst_no_done", n_done, 0);
            chk("rst_idle", busy, 0);
            exp_iss.delete();
            exp_mac.delete();
            return;
        end

        chk("done_seen", done_cyc >= 0, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("done_once", n_done, 1);
        chk("busy_after", busy, 0);
        if (bad) begin
            chk("err_set", err, 1);
            chk("err_no_rd", n_rd, 0);
            chk("err_done_t2", done_cyc, t + 2);
`ifdef CONV_SCHED_PERF_EN
            chk("perf_cyc_err", perf_cycles, 1);
            chk("perf_stall_err", perf_stalls, 0);
`endif
        end else begin
            stalls = 0;
            for (int cc = t + 2; cc < last_rd_cyc; cc++)
                if (st_at.exists(cc) && st_at[cc]) stalls++;
            chk("err_clear_end", err, 0);
            chk("issue_count", n_rd, tot);
            chk("iss_left", exp_iss.size(), 0);
            chk("mac_left", exp_mac.size(), 0);
            chk("last_count", n_last, oh * ow);
            chk("first_rd_t2", first_rd_cyc, t + 2);
            chk("stall_gaps", last_rd_cyc - first_rd_cyc + 1 - n_rd, stalls);
            chk("done_after_mv", done_cyc, last_mv_cyc + 1);
`ifdef CONV_SCHED_PERF_EN
            chk("perf_cycles", perf_cycles, done_cyc - t - 1);
            chk("perf_stalls", perf_stalls, stalls);
`endif
        end
    endtask

    initial begin
        int ih, iw, ch, k;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset_state");
        rst = 1'b0;

        run_cfg(3, 3, 1, 2, 0, 0, 0, 0);
        chk("t1_issues", n_rd, 16);
        chk("t1_f0", qget(obs_f, 0), 0);
        chk("t1_f1", qget(obs_f, 1), 1);
        chk("t1_f2", qget(obs_f, 2), 3);
        chk("t1_f3", qget(obs_f, 3), 4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_k", qget(obs_k, i), i);
            chk("t1_idx", qget(obs_idx, i), i);
        end

        run_cfg(5, 5, 1, 3, 1, 0, 0, 0);
        chk("t2_issues", n_rd, 36);
        chk("t2_pix1", qget(obs_f, 9), 2);
        chk("t2_pix2", qget(obs_f, 18), 10);

        run_cfg(3, 3, 2, 2, 0, 100, 50, 0);
        chk("t3_f4", qget(obs_f, 4), 109);
        chk("t3_f5", qget(obs_f, 5), 110);
        chk("t3_f6", qget(obs_f, 6), 112);
        chk("t3_f7", qget(obs_f, 7), 113);
        for (int i = 0; i < 4; i++) chk("t3_k", qget(obs_k, 4 + i), 54 + i);
        chk("t3_firsts", n_first, 4);

        run_cfg(3, 3, 1, 4, 0, 0, 0, 0);
        chk("t4_err", err, 1);
        run_cfg(3, 3, 1, 2, 0, 0, 0, 0);

        run_cfg(4, 4, 1, 2, 0, 7, 9, 2);
        chk("t5_span", last_rd_cyc - first_rd_cyc + 1, 39);

        run_cfg(1, 1, 1, 1, 0, 4095, 4095, 0);
        chk("k1_first", n_first, 1);
        chk("k1_last", n_last, 1);

        run_cfg(4, 4, 2, 2, 0, 0, 0, 3);
        run_cfg(3, 3, 1, 2, 0, 0, 0, 0);
        chk("t6_restart", qget(obs_f, 0), 0);

        run_cfg(6, 6, 3, 2, 0, 4000, 4090, 1);

        for (int r = 0; r < 30; r++) begin
            ih = $urandom_range(1, 7);
            iw = $urandom_range(1, 7);
            ch = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3);
            k  = $urandom_range(0, ((ih < iw) ? ih : iw) + 1);
            run_cfg(ih, iw, ch, k, $urandom_range(0, 1),
                    $urandom_range(0, 4095), $urandom_range(0, 4095),
                    $urandom_range(0, 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
